stack_seq: RTL and testbench

Micro-sequencer for the PUSH and POP instructions on the shared single-bus datapath. It owns the stack pointer and handles one stack transfer per request. For each request it drives the address-register strobe, the RAM read/write strobes and the register-file bus strobes, one transfer at a time. The main instruction controller hands a request over with a one-cycle `start` pulse and waits for `done`. During that time `stack_seq` is the only block that drives these strobes.

---
 rtl/stack_seq.sv | 152 +++++++++++++++
 tb/tb_stack_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// stack_seq: PUSH/POP micro-sequencer for the single-bus datapath.
// Owns the stack pointer and drives MAR, RAM and register-file strobes
// for one stack transfer per start pulse.
//
// state | meaning
// IDLE  | waiting for start; sp_load honoured here
// ADDR  | iaddr high, addr presented to the MAR
// XFER  | RAM strobe plus one register strobe
// UPD   | SP stepped, done pulse; also accepts the next start
// FLT   | request rejected, done+fault pulse; also accepts the next start
module stack_seq #(
  parameter int             AW          = 8,
  parameter logic [AW-1:0]  STACK_BASE  = 8'hFF,
  parameter logic [AW-1:0]  STACK_LIMIT = 8'hC0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op_push,
  input  logic          op_pop,
  input  logic [2:0]    reg_sel,
  input  logic          sp_load,
  input  logic [AW-1:0] sp_din,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [AW-1:0] sp_out,
  output logic [AW-1:0] addr,
  output logic          iaddr,
  output logic          iram,
  output logic          eram,
  output logic          idr_0,
  output logic          idr_1,
  output logic          idr_bp,
  output logic          edr_0,
  output logic          edr_1,
  output logic          edr_bp
);

  typedef enum logic [2:0] {IDLE, ADDR, XFER, UPD, FLT} state_t;

  state_t        state_q;
  logic [AW-1:0] sp_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] sp_d;
  logic          busy_q, done_q, fault_q, iaddr_q, iram_q, eram_q;
  logic [2:0]    idr_q;   // bit0 r0, bit1 bp, bit2 r1 (same as reg_sel codes)
  logic [2:0]    edr_q;
  logic [2:0]    sel_q;
  logic          push_q;

  logic full, empty, sel_ok, req_bad, req_window;

  assign full    = (sp_q == STACK_LIMIT - AW'(1));
  assign empty   = (sp_q == STACK_BASE);
  assign sel_ok  = (reg_sel == 3'b001) || (reg_sel == 3'b010) || (reg_sel == 3'b100);
  assign req_bad = (op_push == op_pop) || !sel_ok || (op_push && full) || (op_pop && empty);

  // The done cycle doubles as an idle slot so requests can run every 3 cycles.
  assign req_window = (state_q == IDLE) || (state_q == UPD) || (state_q == FLT);

  // POP reads the slot just above SP; PUSH writes the free slot at SP.
  assign addr_d = op_push ? sp_q : sp_q + AW'(1);
  assign sp_d   = push_q ? sp_q - AW'(1) : sp_q + AW'(1);

  // Sequencer state, stack pointer and all registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sp_q    <= STACK_BASE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      iaddr_q <= 1'b0;
      iram_q  <= 1'b0;
      eram_q  <= 1'b0;
      idr_q   <= '0;
      edr_q   <= '0;
      sel_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      iaddr_q <= 1'b0;
      iram_q  <= 1'b0;
      eram_q  <= 1'b0;
      idr_q   <= '0;
      edr_q   <= '0;
      if (req_window) begin
        busy_q <= 1'b0;
        if (start) begin
          push_q <= op_push;
          sel_q  <= reg_sel;
          if (req_bad) begin
            state_q <= FLT;
            fault_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= ADDR;
            fault_q <= 1'b0;
            busy_q  <= 1'b1;
            iaddr_q <= 1'b1;
            addr_q  <= addr_d;
          end
        end else begin
          state_q <= IDLE;
          if (sp_load && (state_q == IDLE)) sp_q <= sp_din;
        end
      end else begin
        case (state_q)
          ADDR: begin
            state_q <= XFER;
            if (push_q) begin
              iram_q <= 1'b1;
              edr_q  <= sel_q;
            end else begin
              eram_q <= 1'b1;
              idr_q  <= sel_q;
            end
          end
          XFER: begin
            state_q <= UPD;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sp_q    <= sp_d;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign fault  = fault_q;
  assign sp_out = sp_q;
  assign addr   = addr_q;
  assign iaddr  = iaddr_q;
  assign iram   = iram_q;
  assign eram   = eram_q;
  assign idr_0  = idr_q[0];
  assign idr_bp = idr_q[1];
  assign idr_1  = idr_q[2];
  assign edr_0  = edr_q[0];
  assign edr_bp = edr_q[1];
  assign edr_1  = edr_q[2];

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed scenarios followed by random requests,
// checked by a scoreboard fed from a queue-level stack model.
module tb_stack_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, op_push = 1'b0, op_pop = 1'b0, sp_load = 1'b0;
  logic [2:0] reg_sel = 3'd0;
  logic [7:0] sp_din = 8'd0;
  logic       busy, done, fault, iaddr, iram, eram;
  logic       idr_0, idr_1, idr_bp, edr_0, edr_1, edr_bp;
  logic [7:0] sp_out, addr;

  stack_seq #(.AW(8), .STACK_BASE(8'hFF), .STACK_LIMIT(8'hC0)) dut (
    .clk(clk), .reset(reset), .start(start), .op_push(op_push), .op_pop(op_pop),
    .reg_sel(reg_sel), .sp_load(sp_load), .sp_din(sp_din),
    .busy(busy), .done(done), .fault(fault), .sp_out(sp_out), .addr(addr),
    .iaddr(iaddr), .iram(iram), .eram(eram),
    .idr_0(idr_0), .idr_1(idr_1), .idr_bp(idr_bp),
    .edr_0(edr_0), .edr_1(edr_1), .edr_bp(edr_bp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         flt;
    logic [7:0] addr;
    logic [7:0] strb;   // {iram,eram,idr_0,idr_1,idr_bp,edr_0,edr_1,edr_bp}
    logic [7:0] sp;
    int         t0;     // cycle index of the edge that samples start
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: stack pointer and sticky fault flag.
  int m_sp = 255;
  bit m_fault = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {iram, eram, idr_0, idr_1, idr_bp, edr_0, edr_1, edr_bp};
  endfunction

  function automatic exp_t predict(bit p, bit q, logic [2:0] sel);
    exp_t e;
    logic [2:0] oh;
    bit bad;
    bad = (p == q) || !(sel == 3'd1 || sel == 3'd2 || sel == 3'd4)
          || (p && m_sp == 'hBF) || (q && m_sp == 'hFF);
    e.flt = bad;
    e.t0  = 0;
    e.addr = 8'h00;
    e.strb = 8'h00;
    if (!bad) begin
      oh = (sel == 3'd1) ? 3'b100 : (sel == 3'd4) ? 3'b010 : 3'b001;
      if (p) begin
        e.addr = 8'(m_sp);
        e.strb = {2'b10, 3'b000, oh};
        m_sp   = (m_sp + 255) % 256;
      end else begin
        e.addr = 8'((m_sp + 1) % 256);
        e.strb = {2'b01, oh, 3'b000};
        m_sp   = (m_sp + 1) % 256;
      end
    end
    m_fault = bad;
    e.sp = 8'(m_sp);
    return e;
  endfunction

  // Monitor: accumulates what the DUT shows and scores it on every done.
  int         ci, cs, n_ia, n_st, ovl;
  logic [7:0] st_or, a_seen, st;
  always @(negedge clk) begin
    if (!reset) begin
      ci = -1; cs = -1; n_ia = 0; n_st = 0; ovl = 0; st_or = 0; a_seen = 0;
    end else begin
      st = strobes();
      if (iaddr) begin
        n_ia++; ci = cyc; a_seen = addr;
        if (st != 0 || !busy) ovl++;
      end
      if (st != 0) begin
        n_st++; cs = cyc; st_or |= st;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("fault", fault, e.flt);
          check("sp_out", sp_out, e.sp);
          check("busy_at_done", busy, 0);
          check("strobes", st_or, e.strb);
          check("done_cycle", cyc, e.t0 + (e.flt ? 0 : 2));
          check("iaddr_count", n_ia, e.flt ? 0 : 1);
          check("iaddr_overlap", ovl, 0);
          if (!e.flt) begin
            check("addr", a_seen, e.addr);
            check("addr_hold", addr, e.addr);
            check("iaddr_cycle", ci, e.t0);
            check("strobe_cycle", cs, e.t0 + 1);
            check("strobe_count", n_st, 1);
          end
        end
        ci = -1; cs = -1; n_ia = 0; n_st = 0; ovl = 0; st_or = 0;
      end
    end
  end

  // Issue one request at the current negedge; returns at the done negedge.
  task automatic do_req(bit p, bit q, logic [2:0] sel, bit junk,
                        bit with_load = 1'b0, logic [7:0] ld = 8'h00);
    exp_t e;
    bit got = 1'b0;
    e = predict(p, q, sel);
    e.t0 = cyc + 1;
    sb_q.push_back(e);
    start = 1'b1; op_push = p; op_pop = q; reg_sel = sel;
    sp_load = with_load; sp_din = ld;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0; sp_load = 1'b0; got = 1'b1;
        break;
      end
      start   = junk && !e.flt;
      sp_load = junk && !e.flt;
      if (junk) begin
        op_push = 1'($urandom); op_pop = ~op_push;
        reg_sel = 3'd1; sp_din = 8'($urandom);
      end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within 6 cycles");
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(logic [7:0] v);
    sp_load = 1'b1; sp_din = v;
    @(negedge clk);
    sp_load = 1'b0;
    m_sp = int'(v);
    check("sp_load", sp_out, v);
  endtask

  initial begin
    idle(2);
    check("rst_sp", sp_out, 8'hFF);
    check("rst_addr", addr, 8'h00);
    check("rst_ctrl", {busy, done, fault, iaddr}, 4'b0000);
    check("rst_strobes", strobes(), 8'h00);
    reset = 1'b1;
    idle(1);

    do_req(1, 0, 3'd1, 0);                 // push r0: addr FF, SP -> FE
    idle(1);
    do_req(0, 1, 3'd2, 0);                 // pop bp: addr FF, SP -> FF
    idle(1);
    do_req(0, 1, 3'd1, 0);                 // underflow
    idle(1);
    check("fault_sticky_uf", fault, m_fault);

    load(8'hBF);
    do_req(1, 0, 3'd4, 0);                 // overflow
    do_req(1, 0, 3'd3, 0);                 // illegal reg_sel, back-to-back
    idle(1);
    check("fault_sticky_ovf", fault, m_fault);
    load(8'hC0);
    do_req(1, 0, 3'd4, 0);                 // push r1 into lowest slot
    idle(1);
    check("fault_cleared", fault, m_fault);

    do_req(0, 1, 3'd4, 1);                 // junk start/sp_load during ADDR/XFER
    idle(1);
    do_req(1, 0, 3'd2, 0, 1'b1, 8'h10);    // same-cycle sp_load is dropped
    idle(1);
    load(8'hFF);

    // Reset while a PUSH is in XFER.
    start = 1'b1; op_push = 1'b1; op_pop = 1'b0; reg_sel = 3'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_strobes", strobes(), 8'h00);
    check("midrst_ctrl", {busy, done, fault, iaddr}, 4'b0000);
    check("midrst_sp", sp_out, 8'hFF);
    sb_q.delete();
    m_sp = 255; m_fault = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    do_req(1, 0, 3'd1, 0);                 // same as first push

    for (int n = 0; n < 250; n++) begin
      bit p, q;
      logic [2:0] sel;
      p = ($urandom_range(0, 9) != 0) ? 1'($urandom) : 1'b1;
      q = ($urandom_range(0, 9) != 0) ? ~p : 1'($urandom);
      sel = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
      do_req(p, q, sel, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) begin
        idle(1 + $urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0: load(8'hBF);
            1: load(8'hC0);
            2: load(8'hFF);
            default: load(8'($urandom_range(8'hC0, 8'hFE)));
          endcase
        end
      end
    end

    idle(3);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
